des_iter_engine: RTL and testbench
==================================

// Module: des_iter_engine
// PURPOSE
// - Iterative DES (FIPS 46-3) encrypt/decrypt engine. Generalises the fixed 16-round pipeline
//   to a configurable rounds-per-cycle datapath, trading area against latency.
// - Adds ready/valid flow control on both sides and an optional CBC chaining mode.
// - Sits between the block-buffer front end and the output formatter. One block in flight.
// PARAMETERS
// - ROUNDS_PER_CYCLE  1  DES rounds unrolled per clock. Legal: 1,2,4,8,16. Others fail
//                        elaboration (generate guard). LAT = 16/ROUNDS_PER_CYCLE.
// PORTS
// - clk        in   1   clock, rising edge
// - rstn       in   1   asynchronous reset, active low
// - in_valid   in   1   input block valid
// - in_ready   out  1   engine can accept; high only in IDLE
// - in_text    in   64  plaintext (encrypt) or ciphertext (decrypt)
// - in_key     in   64  key incl. parity bits; parity ignored, PC-1 drops them
// - in_decrypt in   1   0=encrypt, 1=decrypt; sampled with block
// - out_valid  out  1   result valid; held until accepted
// - out_ready  in   1   downstream accepts result
// - out_text   out  64  result block
// - busy       out  1   high in RUN or DONE
// - iv         in   64  [DES_CBC_EN only] initial chaining value
// - iv_load    in   1   [DES_CBC_EN only] load iv into chain register
// BEHAVIOUR
// - Reset (rstn low, async): state=IDLE, out_valid=0, out_text=0, round counter=0,
//   internal L/R/C/D=0, chain=0. in_ready=0 while rstn low, 1 from the first edge after release.
// - FSM: IDLE -> RUN on accept (in_valid & in_ready). RUN -> DONE after LAT cycles.
//   DONE -> IDLE on out_valid & out_ready. No other transitions.
// - Accept edge: L/R <= IP(in_text); C/D <= PC-1(in_key); dir <= in_decrypt; rcnt <= 0.
// - RUN: each edge applies ROUNDS_PER_CYCLE rounds; rcnt += ROUNDS_PER_CYCLE (5-bit).
//   Encrypt: C/D rotate left 1 or 2 per standard shift schedule before PC-2.
//   Decrypt: round 1 uses unrotated C/D; later rounds rotate right by the mirrored schedule.
//   This yields subkeys K16..K1.
// - Last RUN edge (rcnt+R==16): out_text <= FP(R16||L16) (swap), out_valid <= 1, state <= DONE.
// - Latency: accept at edge t -> out_valid high after edge t+LAT (LAT=16 for R=1, 1 for R=16).
// - DONE: out_text and out_valid stable while out_ready low. in_ready=0.
// - out_valid falls on the edge where out_ready=1. in_ready rises the same edge (IDLE).
//   No accept in the same cycle as output handshake; throughput = 1 block / (LAT+2) cycles.
// - in_* ignored when in_ready=0. in_ready is combinational from state only, not from in_valid.
// - Reset mid-RUN/DONE: block discarded, no out_valid pulse, engine returns to IDLE.
// CONFIGURATION
// - DES_CBC_EN defined: a 64-bit chain register is added, plus the iv and iv_load ports.
//   - iv_load in IDLE: chain <= iv. iv_load outside IDLE is ignored.
//   - iv_load and accept in the same cycle: the new iv is used for that block.
//   - Encrypt: IP input = in_text ^ chain. On completion chain <= result ciphertext.
//   - Decrypt: out_text = FP(...) ^ chain. On accept the captured in_text is held; on
//     completion chain <= held in_text.
//   - Reset clears chain to 0.
// - DES_CBC_EN undefined: pure ECB. No iv/iv_load ports, no chain register.
// TESTING
// - ECB enc, R=1: key 133457799BBCDFF1, text 0123456789ABCDEF -> out_text 85E813540F0AB405.
//   out_valid exactly 16 cycles after the accept edge.
// - ECB dec, R=1: key 133457799BBCDFF1, text 85E813540F0AB405 -> 0123456789ABCDEF.
//   Repeat both directions for R=2,4,8,16 with LAT 8,4,2,1.
// - Vector 2: key 0E329232EA6D0D73, text 8787878787878787 -> 0000000000000000.
//   Flipping all key parity bits (LSB of each byte) gives the same result.
// - Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_text stable, in_ready=0,
//   in_valid pulses ignored. Release -> one handshake, then IDLE with in_ready=1.
// - Reset mid-op: assert rstn low at RUN cycle 7 (R=1) -> out_valid=0, out_text=0
//   immediately. After release the next block encrypts correctly.
// - CBC (DES_CBC_EN): iv=0 -> block1 equals ECB. Block2 P2 -> ECB(P2^C1).
//   Decrypting C1,C2 with iv=0 returns P1,P2. iv_load during RUN has no effect.

Source files
------------

// File: rtl/des_iter_engine.sv
// Iterative DES (FIPS 46-3) encrypt/decrypt engine, ROUNDS_PER_CYCLE rounds per clock, one block in flight.
// Define DES_CBC_EN to add CBC chaining (chain register plus iv/iv_load ports); default build is ECB only.
module des_iter_engine #(
    parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_text,
    input  logic [63:0] in_key,
    input  logic        in_decrypt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_text,
`ifdef DES_CBC_EN
    input  logic [63:0] iv,
    input  logic        iv_load,
`endif
    output logic        busy
);

    localparam int unsigned RCNT_W = 5;

    if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4 ||
          ROUNDS_PER_CYCLE == 8 || ROUNDS_PER_CYCLE == 16)) begin : g_bad_rpc
        $error("des_iter_engine: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    localparam int unsigned IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
    localparam int unsigned FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
    localparam int unsigned PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int unsigned PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    localparam int unsigned E_T [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
    localparam int unsigned P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
    localparam int unsigned SHIFT_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    // S-box contents, indexed {row, col} = row*16 + col
    localparam logic [3:0] SBOX [8][64] = '{
        '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,  0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
           4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0, 15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
        '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,  3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
           0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15, 13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
        '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
          13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,  1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
        '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15, 13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
          10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,  3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
        '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9, 14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
           4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14, 11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
        '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11, 10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
           9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,  4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
        '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1, 13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
           1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,  6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
        '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,  1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
           7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,  2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

    // Table-driven permutations; table entries use DES numbering (bit 1 = MSB)
    function automatic logic [63:0] perm_ip(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_T[6'(i)])];
        return y;
    endfunction

    function automatic logic [63:0] perm_fp(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_T[6'(i)])];
        return y;
    endfunction

    function automatic logic [55:0] perm_pc1(input logic [63:0] x);
        logic [55:0] y;
        for (int i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - PC1_T[6'(i)])];
        return y;
    endfunction

    function automatic logic [47:0] perm_pc2(input logic [55:0] x);
        logic [47:0] y;
        for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - PC2_T[6'(i)])];
        return y;
    endfunction

    function automatic logic [47:0] expand(input logic [31:0] x);
        logic [47:0] y;
        for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[5'(32 - E_T[6'(i)])];
        return y;
    endfunction

    function automatic logic [31:0] perm_p(input logic [31:0] x);
        logic [31:0] y;
        for (int i = 0; i < 32; i++) y[5'(31 - i)] = x[5'(32 - P_T[5'(i)])];
        return y;
    endfunction

    function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s;
        logic [5:0]  six;
        x = expand(r) ^ k;
        s = '0;
        for (int b = 0; b < 8; b++) begin
            six = x[6'(47 - 6 * b) -: 6];
            s[5'(31 - 4 * b) -: 4] = SBOX[3'(b)][{six[5], six[0], six[4:1]}];
        end
        return perm_p(s);
    endfunction

    function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state, state_nx;
    logic                live_q;
    logic                dir_q;
    logic [RCNT_W-1:0]   rcnt_q;
    logic [31:0]         l_q, r_q, l_nx, r_nx;
    logic [27:0]         c_q, d_q, c_nx, d_nx;
    logic [63:0]         blk_in_c;
    logic [63:0]         result_c;
    logic                accept_c, last_c, hshake_c;
`ifdef DES_CBC_EN
    logic [63:0]         chain_q, held_q;
`endif

    assign in_ready = live_q && (state == IDLE);
    assign busy     = (state == RUN) || (state == DONE);

    always_ff @(posedge clk or negedge rstn) begin : state_reg
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin : fsm_comb
        state_nx = state;
        accept_c = 1'b0;
        last_c   = 1'b0;
        hshake_c = 1'b0;
        case (state)
            IDLE: if (in_valid && in_ready) begin
                accept_c = 1'b1;
                state_nx = RUN;
            end
            RUN: if (rcnt_q + RCNT_W'(ROUNDS_PER_CYCLE) == RCNT_W'(16)) begin
                last_c   = 1'b1;
                state_nx = DONE;
            end
            DONE: if (out_valid && out_ready) begin
                hshake_c = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Unrolled rounds; decrypt walks the key schedule backwards to produce K16..K1
    always_comb begin : round_comb
        logic [3:0]  rn;
        logic [31:0] tmp;
        rn   = '0;
        tmp  = '0;
        l_nx = l_q;
        r_nx = r_q;
        c_nx = c_q;
        d_nx = d_q;
        for (int k = 0; k < int'(ROUNDS_PER_CYCLE); k++) begin
            rn = rcnt_q[3:0] + 4'(k);
            if (!dir_q) begin
                c_nx = rotl(c_nx, SHIFT_T[rn] == 32'd2);
                d_nx = rotl(d_nx, SHIFT_T[rn] == 32'd2);
            end else if (rn != 4'd0) begin
                c_nx = rotr(c_nx, SHIFT_T[4'(4'd0 - rn)] == 32'd2);
                d_nx = rotr(d_nx, SHIFT_T[4'(4'd0 - rn)] == 32'd2);
            end
            tmp  = r_nx;
            r_nx = l_nx ^ feistel(r_nx, perm_pc2({c_nx, d_nx}));
            l_nx = tmp;
        end
    end

`ifdef DES_CBC_EN
    // A same-cycle iv_load takes effect for the block being accepted
    assign blk_in_c = in_decrypt ? in_text : (in_text ^ (iv_load ? iv : chain_q));
    assign result_c = perm_fp({r_nx, l_nx}) ^ (dir_q ? chain_q : 64'd0);
`else
    assign blk_in_c = in_text;
    assign result_c = perm_fp({r_nx, l_nx});
`endif

    always_ff @(posedge clk or negedge rstn) begin : datapath_reg
        if (!rstn) begin
            live_q    <= 1'b0;
            dir_q     <= 1'b0;
            rcnt_q    <= '0;
            l_q       <= '0;
            r_q       <= '0;
            c_q       <= '0;
            d_q       <= '0;
            out_valid <= 1'b0;
            out_text  <= '0;
        end else begin
            live_q <= 1'b1;
            if (accept_c) begin
                {l_q, r_q} <= perm_ip(blk_in_c);
                {c_q, d_q} <= perm_pc1(in_key);
                dir_q      <= in_decrypt;
                rcnt_q     <= '0;
            end else if (state == RUN) begin
                l_q    <= l_nx;
                r_q    <= r_nx;
                c_q    <= c_nx;
                d_q    <= d_nx;
                rcnt_q <= rcnt_q + RCNT_W'(ROUNDS_PER_CYCLE);
                if (last_c) begin
                    out_text  <= result_c;
                    out_valid <= 1'b1;
                end
            end else if (hshake_c) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef DES_CBC_EN
    // Chain follows ciphertext: produced ciphertext on encrypt, consumed ciphertext on decrypt
    always_ff @(posedge clk or negedge rstn) begin : chain_reg
        if (!rstn) begin
            chain_q <= '0;
            held_q  <= '0;
        end else begin
            if (state == IDLE && iv_load) chain_q <= iv;
            if (accept_c)                 held_q  <= in_text;
            if (last_c)                   chain_q <= dir_q ? held_q : result_c;
        end
    end
`endif

endmodule

// File: tb/tb_des_iter_engine.sv
// Directed bench for des_iter_engine: one instance per legal ROUNDS_PER_CYCLE, all driven by shared stimulus.
`timescale 1ns/1ps
module tb_des_iter_engine;

    localparam int unsigned NI = 5;
    localparam int unsigned RPC [NI] = '{1, 2, 4, 8, 16};

    localparam logic [63:0] KEY1  = 64'h133457799BBCDFF1;
    localparam logic [63:0] P1    = 64'h0123456789ABCDEF;
    localparam logic [63:0] C1    = 64'h85E813540F0AB405;
    localparam logic [63:0] KEY2  = 64'h0E329232EA6D0D73;
    localparam logic [63:0] KEY2P = 64'h0F339333EB6C0C72;
    localparam logic [63:0] T2    = 64'h8787878787878787;
    localparam logic [63:0] P2    = 64'h84CB563386A179EA;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_decrypt = 1'b0;
    logic        out_ready = 1'b1;
    logic [63:0] in_text = '0;
    logic [63:0] in_key = '0;
`ifdef DES_CBC_EN
    logic        iv_load = 1'b0;
    logic [63:0] iv = '0;
`endif
    logic        ir [NI];
    logic        ov [NI];
    logic        bz [NI];
    logic [63:0] ot [NI];

    int          errors = 0;
    int          checks = 0;
    logic [63:0] res_a [NI];
    int          lat_a [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < int'(NI); g++) begin : g_dut
        des_iter_engine #(.ROUNDS_PER_CYCLE(RPC[g])) dut (
            .clk(clk), .rstn(rstn),
            .in_valid(in_valid), .in_ready(ir[g]), .in_text(in_text),
            .in_key(in_key), .in_decrypt(in_decrypt),
            .out_valid(ov[g]), .out_ready(out_ready), .out_text(ot[g]),
`ifdef DES_CBC_EN
            .iv(iv), .iv_load(iv_load),
`endif
            .busy(bz[g]));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] t, input logic [63:0] k, input logic d);
        int n;
        n = 0;
        while (!ir[0] && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (ir[0] !== 1'b1) begin
            errors++;
            $display("FAIL send_wait_ready in_ready=%0b required 1", ir[0]);
        end
        in_valid = 1'b1; in_text = t; in_key = k; in_decrypt = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic run_block(input logic [63:0] t, input logic [63:0] k, input logic d);
        for (int i = 0; i < int'(NI); i++) begin
            lat_a[i] = -1;
            res_a[i] = '0;
        end
        send(t, k, d);
        for (int c = 1; c <= 20; c++) begin
            tick();
            for (int i = 0; i < int'(NI); i++)
                if (ov[i] && lat_a[i] < 0) begin
                    lat_a[i] = c;
                    res_a[i] = ot[i];
                end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        #12;
        checks++; if (ir[0] !== 1'b0)  begin errors++; $display("FAIL reset_in_ready got=%0b want=0", ir[0]); end
        checks++; if (ov[0] !== 1'b0)  begin errors++; $display("FAIL reset_out_valid got=%0b want=0", ov[0]); end
        checks++; if (ot[0] !== 64'd0) begin errors++; $display("FAIL reset_out_text got=%h want=0", ot[0]); end
        checks++; if (bz[0] !== 1'b0)  begin errors++; $display("FAIL reset_busy got=%0b want=0", bz[0]); end
        tick();
        rstn = 1'b1;
        tick();
        checks++; if (ir[0] !== 1'b1)  begin errors++; $display("FAIL reset_release_in_ready got=%0b want=1", ir[0]); end
    endtask

    task automatic test_ecb();
        run_block(P1, KEY1, 1'b0);
        for (int i = 0; i < int'(NI); i++) begin
            checks++;
            if (res_a[i] !== C1) begin errors++; $display("FAIL ecb_enc_r%0d got=%h want=%h", RPC[i], res_a[i], C1); end
            checks++;
            if (lat_a[i] != int'(16 / RPC[i])) begin errors++; $display("FAIL ecb_enc_lat_r%0d got=%0d want=%0d", RPC[i], lat_a[i], 16 / RPC[i]); end
        end
        run_block(C1, KEY1, 1'b1);
        for (int i = 0; i < int'(NI); i++) begin
            checks++;
            if (res_a[i] !== P1) begin errors++; $display("FAIL ecb_dec_r%0d got=%h want=%h", RPC[i], res_a[i], P1); end
            checks++;
            if (lat_a[i] != int'(16 / RPC[i])) begin errors++; $display("FAIL ecb_dec_lat_r%0d got=%0d want=%0d", RPC[i], lat_a[i], 16 / RPC[i]); end
        end
    endtask

    task automatic test_vector2();
        run_block(T2, KEY2, 1'b0);
        checks++; if (res_a[0] !== 64'd0) begin errors++; $display("FAIL vec2_r1 got=%h want=0", res_a[0]); end
        checks++; if (res_a[4] !== 64'd0) begin errors++; $display("FAIL vec2_r16 got=%h want=0", res_a[4]); end
        run_block(T2, KEY2P, 1'b0);
        checks++; if (res_a[0] !== 64'd0) begin errors++; $display("FAIL vec2_parity_r1 got=%h want=0", res_a[0]); end
        checks++; if (res_a[2] !== 64'd0) begin errors++; $display("FAIL vec2_parity_r4 got=%h want=0", res_a[2]); end
    endtask

    task automatic test_backpressure();
        int n;
        out_ready = 1'b0;
        send(P1, KEY1, 1'b0);
        n = 0;
        while (!ov[0] && n < 30) begin
            tick();
            n++;
        end
        checks++; if (ov[0] !== 1'b1) begin errors++; $display("FAIL bp_out_valid got=%0b want=1", ov[0]); end
        for (int c = 0; c < 5; c++) begin
            in_valid = ~c[0];
            in_text  = 64'hFFFF_FFFF_FFFF_FFFF;
            tick();
            checks++; if (ot[0] !== C1)   begin errors++; $display("FAIL bp_text_c%0d got=%h want=%h", c, ot[0], C1); end
            checks++; if (ov[0] !== 1'b1) begin errors++; $display("FAIL bp_valid_c%0d got=%0b want=1", c, ov[0]); end
            checks++; if (ir[0] !== 1'b0) begin errors++; $display("FAIL bp_ready_c%0d got=%0b want=0", c, ir[0]); end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        checks++; if (ov[0] !== 1'b0) begin errors++; $display("FAIL bp_release_valid got=%0b want=0", ov[0]); end
        checks++; if (ir[0] !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%0b want=1", ir[0]); end
        tick();
        checks++; if (bz[0] !== 1'b0) begin errors++; $display("FAIL bp_no_stray_accept busy=%0b want=0", bz[0]); end
    endtask

    task automatic test_reset_mid();
        send(P1, KEY1, 1'b0);
        for (int c = 0; c < 6; c++) tick();
        rstn = 1'b0;
        #1;
        checks++; if (ov[0] !== 1'b0)  begin errors++; $display("FAIL midrst_valid got=%0b want=0", ov[0]); end
        checks++; if (ot[0] !== 64'd0) begin errors++; $display("FAIL midrst_text got=%h want=0", ot[0]); end
        checks++; if (bz[0] !== 1'b0)  begin errors++; $display("FAIL midrst_busy got=%0b want=0", bz[0]); end
        tick();
        rstn = 1'b1;
        tick();
        run_block(P1, KEY1, 1'b0);
        checks++; if (res_a[0] !== C1) begin errors++; $display("FAIL midrst_after got=%h want=%h", res_a[0], C1); end
        checks++; if (lat_a[0] != 16)  begin errors++; $display("FAIL midrst_after_lat got=%0d want=16", lat_a[0]); end
    endtask

    task automatic test_back_to_back();
        int t0, t1;
        t0 = -1; t1 = -1;
        in_valid = 1'b1; in_text = P1; in_key = KEY1; in_decrypt = 1'b0;
        for (int c = 0; c < 60 && t1 < 0; c++) begin
            if (ir[0]) begin
                if (t0 < 0) t0 = c;
                else        t1 = c;
            end
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (t0 < 0 || t1 < 0 || (t1 - t0) != 18) begin
            errors++; $display("FAIL b2b_period got=%0d want=18", t1 - t0);
        end
        for (int c = 0; c < 40; c++) tick();
    endtask

`ifdef DES_CBC_EN
    task automatic load_iv(input logic [63:0] v);
        iv = v; iv_load = 1'b1;
        tick();
        iv_load = 1'b0;
    endtask

    task automatic test_cbc();
        logic [63:0] got;
        load_iv(64'd0);
        run_block(P1, KEY1, 1'b0);
        checks++; if (res_a[0] !== C1) begin errors++; $display("FAIL cbc_enc_b1 got=%h want=%h", res_a[0], C1); end
        run_block(P2, KEY1, 1'b0);
        checks++; if (res_a[0] !== C1) begin errors++; $display("FAIL cbc_enc_b2 got=%h want=%h", res_a[0], C1); end
        load_iv(64'd0);
        send(P1, KEY1, 1'b0);
        got = '0;
        for (int c = 1; c <= 20; c++) begin
            iv      = 64'hFFFF_FFFF_FFFF_FFFF;
            iv_load = (c >= 2 && c <= 6);
            tick();
            if (ov[0]) got = ot[0];
        end
        iv_load = 1'b0;
        checks++; if (got !== C1) begin errors++; $display("FAIL cbc_ivload_run got=%h want=%h", got, C1); end
        run_block(P2, KEY1, 1'b0);
        checks++; if (res_a[0] !== C1) begin errors++; $display("FAIL cbc_ivload_chain got=%h want=%h", res_a[0], C1); end
        load_iv(64'd0);
        run_block(C1, KEY1, 1'b1);
        checks++; if (res_a[0] !== P1) begin errors++; $display("FAIL cbc_dec_b1 got=%h want=%h", res_a[0], P1); end
        run_block(C1, KEY1, 1'b1);
        checks++; if (res_a[0] !== P2) begin errors++; $display("FAIL cbc_dec_b2 got=%h want=%h", res_a[0], P2); end
    endtask
`endif

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin : main
        test_reset();
        test_ecb();
        test_vector2();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
`ifdef DES_CBC_EN
        test_cbc();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
